parity_check_stage: RTL and testbench

PARITY_CHECK_STAGE -- requirements
Module: parity_check_stage

---
 rtl/parchk_pkg.sv | 14 +
 rtl/parchk_fifo2.sv | 64 ++++++
 rtl/parity_check_stage.sv | 91 +++++++++
 tb/tb_parity_check_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/parchk_pkg.sv
// Shared types and default parameters for the parity check stage.
package parchk_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_FAULT_THRESH = 3;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/parchk_fifo2.sv
// Two-entry FIFO: head_q drives the output directly, tail_q holds the second word.
module parchk_fifo2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign full      = (count_q == 2'd2);
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count stays put; with one entry the new word goes straight to the head.
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/parity_check_stage.sv
// Even-parity checker: good words are buffered downstream, bad words are dropped
// and tracked by an error counter and an OK/WARN/FAULT state machine.
module parity_check_stage
  import parchk_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             fault,
  input  logic             clr
);

  localparam int              CB_W   = $clog2(FAULT_THRESH + 1);
  localparam logic [CB_W-1:0] THRESH = CB_W'(FAULT_THRESH);

  state_e           state_q, state_d;
  logic [CB_W-1:0]  consec_q, consec_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             fifo_full;
  logic             accept, good, push, bad_acc;

  // ready is forced low during reset so nothing is taken while state is being cleared
  assign in_ready  = ~rst & ~fifo_full & (state_q != ST_FAULT);
  assign accept    = in_valid & in_ready;
  assign good      = ~(^in_data ^ in_par);
  assign push      = accept & good;
  assign bad_acc   = accept & ~good;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign fault     = (state_q == ST_FAULT);

  parchk_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    consec_d    = consec_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    if (clr) begin
      // clr wins over a same-cycle bad word: the word is still dropped but not counted
      state_d     = ST_OK;
      consec_d    = '0;
      err_count_d = '0;
    end else if (bad_acc) begin
      err_pulse_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      if (consec_q != THRESH) consec_d = consec_q + 1'b1;
      state_d = (consec_d == THRESH) ? ST_FAULT : ST_WARN;
    end else if (push) begin
      consec_d = '0;
      state_d  = ST_OK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OK;
      consec_q    <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule

// File: tb/tb_parity_check_stage.sv
// Directed bench for parity_check_stage: a default instance plus a CNT_W=2 instance on shared stimulus.
module tb_parity_check_stage;
  import parchk_pkg::*;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_par, out_ready, clr;
  logic [3:0] in_data;
  logic       in_ready, out_valid, err_pulse, fault;
  logic [3:0] out_data;
  logic [7:0] err_count;
  logic       in_ready_s, out_valid_s, err_pulse_s, fault_s;
  logic [3:0] out_data_s;
  logic [1:0] err_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_check_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_pulse(err_pulse),
    .err_count(err_count), .fault(fault), .clr(clr)
  );

  parity_check_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .err_pulse(err_pulse_s),
    .err_count(err_count_s), .fault(fault_s), .clr(clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic p);
    in_valid = 1'b1; in_data = d; in_par = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_par = 1'b0;
    out_ready = 1'b0; clr = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse got %b exp 0", err_pulse); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault); end
    checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_good_stream();
    out_ready = 1'b1;
    send(4'b1011, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b1011) begin errors++; $display("FAIL good1 got v=%b d=%b exp v=1 d=1011", out_valid, out_data); end
    send(4'b1101, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b1101) begin errors++; $display("FAIL good2 got v=%b d=%b exp v=1 d=1101", out_valid, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_drain got v=%b exp 0", out_valid); end
    checks++; if (err_count !== 8'd0 || fault !== 1'b0) begin errors++; $display("FAIL good_status got cnt=%0d fault=%b exp 0 0", err_count, fault); end
  endtask

  task automatic test_single_bad();
    send(4'b1010, 1'b1);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL bad_pulse got %b exp 1", err_pulse); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_count got %0d exp 1", err_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad_dropped got v=%b exp 0", out_valid); end
    checks++; if (dut.state_q !== ST_WARN) begin errors++; $display("FAIL bad_state got %0d exp WARN", dut.state_q); end
    step();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL bad_pulse_width got %b exp 0", err_pulse); end
    send(4'b0000, 1'b0);
    checks++; if (dut.state_q !== ST_OK) begin errors++; $display("FAIL warn_to_ok got %0d exp OK", dut.state_q); end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0000) begin errors++; $display("FAIL warn_good_out got v=%b d=%b exp 1 0000", out_valid, out_data); end
    step();
  endtask

  task automatic test_fault();
    send(4'b0001, 1'b0);
    send(4'b0001, 1'b0);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_early got %b exp 0", fault); end
    send(4'b0001, 1'b0);
    checks++; if (fault !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fault_set got f=%b rdy=%b exp 1 0", fault, in_ready); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL fault_count got %0d exp 4", err_count); end
    in_valid = 1'b1; in_data = 4'b0011; in_par = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL fault_blocks got v=%b f=%b exp 0 1", out_valid, fault); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (fault !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr got f=%b cnt=%0d rdy=%b exp 0 0 1", fault, err_count, in_ready); end
    clr = 1'b1;
    send(4'b0111, 1'b0);
    clr = 1'b0;
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_priority got p=%b cnt=%0d v=%b exp 0 0 0", err_pulse, err_count, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'b0011, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    send(4'b0101, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_data !== 4'b0011) begin errors++; $display("FAIL bp_full got rdy=%b d=%b exp 0 0011", in_ready, out_data); end
    in_valid = 1'b1; in_data = 4'b0110; in_par = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0011 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold got v=%b d=%b rdy=%b exp 1 0011 0", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 4'b0101 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_order2 got d=%b rdy=%b exp 0101 1", out_data, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0110) begin errors++; $display("FAIL bp_order3 got v=%b d=%b exp 1 0110", out_valid, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [3:0] seq_d [7];
    logic       seq_bad [7];
    int         exp_def, exp_sat;
    seq_d   = '{4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0111};
    seq_bad = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1};
    out_ready = 1'b1;
    clr = 1'b1; step(); clr = 1'b0;
    exp_def = 0; exp_sat = 0;
    for (int i = 0; i < 7; i++) begin
      send(seq_d[i], 1'b0);
      if (seq_bad[i]) begin
        exp_def++;
        if (exp_sat < 3) exp_sat++;
        checks++; if (err_count_s !== 2'(exp_sat)) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, err_count_s, exp_sat); end
        checks++; if (err_count !== 8'(exp_def)) begin errors++; $display("FAIL wide_count[%0d] got %0d exp %0d", i, err_count, exp_def); end
      end
    end
    checks++; if (fault_s !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL sat_no_fault got %b %b exp 0 0", fault_s, fault); end
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if (err_count_s !== 2'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", err_count_s); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(4'b1001, 1'b0);
    send(4'b1110, 1'b1);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got v=%b rdy=%b exp 1 0", out_valid, in_ready); end
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 4'h0) begin errors++; $display("FAIL mid_rst got v=%b d=%h exp 0 0", out_valid, out_data); end
    rst = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_after got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_good_stream();
    test_single_bad();
    test_fault();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
